// File: rtl/q_action_select.sv
// q_action_select: sequential argmax over free board cells, fetching each Q-value over a req/ack port.
// Returns the lowest-index maximum; reports no_move when every cell is occupied.
module q_action_select #(
  parameter int QW     = 8,
  parameter int N_CELL = 9,
  parameter int IDXW   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [N_CELL-1:0] i_occ_mask,
  output logic              o_q_req,
  output logic [IDXW-1:0]   o_q_addr,
  input  logic              i_q_ack,
  input  logic [QW-1:0]     i_q_data,
  output logic              o_busy,
  output logic              o_done,
  output logic [IDXW-1:0]   o_best_idx,
  output logic [QW-1:0]     o_best_q,
  output logic              o_no_move
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  localparam logic [IDXW-1:0] LAST = IDXW'(N_CELL - 1);
  state_t              r_state, w_state_nx;
  logic [N_CELL-1:0]   r_mask;
  logic [IDXW-1:0]     r_idx;
  logic                r_have_best;
  logic [IDXW-1:0]     r_best_idx;
  logic [QW-1:0]       r_best_q;
  logic                r_no_move;
  logic                w_scan, w_free, w_adv, w_take, w_upd, w_hb_nx, w_last, w_accept;
  always_comb begin
    w_scan     = r_state == SCAN;
    w_free     = !r_mask[r_idx];
    w_last     = r_idx == LAST;
    w_accept   = r_state == IDLE && i_start;
    o_q_req    = w_scan && w_free;
    o_q_addr   = w_scan ? r_idx : '0;
    w_take     = o_q_req && i_q_ack;
    w_adv      = w_scan && (!w_free || i_q_ack);
    w_upd      = w_take && (!r_have_best || i_q_data > r_best_q);
    w_hb_nx    = r_have_best || w_take;
    w_state_nx = w_accept ? SCAN :
                 (w_adv && w_last) ? DONE :
                 (r_state == DONE) ? IDLE : r_state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nx;
  // Results are finalised on the SCAN->DONE edge so they are already valid while done is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask      <= '0;
      r_idx       <= '0;
      r_have_best <= 1'b0;
      r_best_idx  <= '0;
      r_best_q    <= '0;
      r_no_move   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_mask      <= i_occ_mask;
        r_idx       <= '0;
        r_have_best <= 1'b0;
      end
      if (w_upd) begin
        r_best_q   <= i_q_data;
        r_best_idx <= r_idx;
      end
      if (w_take) r_have_best <= 1'b1;
      if (w_adv && !w_last) r_idx <= r_idx + 1'b1;
      if (w_adv && w_last) begin
        r_no_move <= !w_hb_nx;
        if (!w_hb_nx) begin
          r_best_idx <= '1;
          r_best_q   <= '0;
        end
      end
    end
  end
  assign o_busy     = r_state != IDLE;
  assign o_done     = r_state == DONE;
  assign o_best_idx = r_best_idx;
  assign o_best_q   = r_best_q;
  assign o_no_move  = r_no_move;
endmodule
